timer_intr_ctrl: RTL and testbench
==================================

# timer_intr_ctrl

Memory-mapped machine-timer peripheral that sits on the core's data-memory bus beside data memory and drives the core's timer-interrupt input. The core reads and writes the timer registers with ordinary loads and stores. The block raises `timer_intr` when the 64-bit `mtime` counter reaches `mtimecmp`. It holds the interrupt until the core acknowledges trap entry, so it is the source end of the core's interrupt/trap path.

## Interface
- `BASE_ADDR`, 32'h0000_F000: base of the 32-byte register window; decode is `addr[31:5] == BASE_ADDR[31:5]`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `addr`  in  32  byte address from the core's ALU result; only `addr[4:2]` selects a register inside the window.
- `wdata`  in  32  store data.
- `rd_en`  in  1  load strobe.
- `wr_en`  in  1  store strobe.
- `rdata`  out  32  load data.
- `intr_ack`  in  1  one-cycle pulse from the core when it takes the timer trap.
- `timer_intr`  out  1  level interrupt request to the core.

## Operation
- Register map (word offsets):
  - 0x00 MTIME_LO, rw.
  - 0x04 MTIME_HI, rw.
  - 0x08 MTIMECMP_LO, rw.
  - 0x0C MTIMECMP_HI, rw.
  - 0x10 CTRL: bit0 EN rw; bit1 PEND ro (1 in FIRED); other bits read 0.
  - 0x14 PRESC, rw [7:0] (macro only).
  - 0x18–0x1C reserved: read 0, writes ignored.
- Reads: `rdata` is combinational from current registers when `rd_en` is high and the address hits the window; otherwise 0.
- Writes: take effect at the next rising edge when `wr_en` is high and the address hits the window.
- mtime increments by 1 per tick while EN=1. A tick is every cycle, or every PRESC+1 cycles with the macro.
- mtime wraps from 2^64−1 to 0. A CPU write to MTIME_LO/HI in the same cycle as a tick wins, and that tick is lost.
- `rd_en` and `wr_en` together: the write is performed and `rdata` shows the pre-write value.
- FSM states and transitions:
  - IDLE: EN=0.
  - IDLE→ARMED on EN write 1.
  - ARMED→FIRED when the registered `mtime >= mtimecmp` (unsigned 64-bit).
  - FIRED→SERVICED on `intr_ack`.
  - SERVICED→ARMED on any write to MTIMECMP_LO or MTIMECMP_HI.
  - Any state→IDLE when EN is written 0; this has top priority.
- Simultaneous `intr_ack` and a mtimecmp write while in FIRED: next state is ARMED, and the compare is re-evaluated on the following cycle.
- `intr_ack` outside FIRED is ignored.
- `timer_intr` = (state == FIRED), registered.

## Timing
- Reset values: mtime 0, mtimecmp 64'hFFFF_FFFF_FFFF_FFFF, EN 0, PRESC 0, prescale counter 0, state IDLE, `timer_intr` 0.
- `rdata` is 0 while the strobes are low.
- Reset asserted mid-operation returns every register to its reset value at the next edge, including dropping `timer_intr`.
- Compare-to-interrupt latency: `timer_intr` rises 1 cycle after the edge where `mtime` first satisfies `>= mtimecmp`.
- Ack-to-deassert latency: `timer_intr` falls at the edge that samples `intr_ack`.
- Read latency is 0; registered effects of a write are visible from the next cycle.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - An 8-bit PRESC register is present at 0x14.
  - The prescale counter reloads on a tick.
  - Writing PRESC clears the prescale counter.
- Not defined:
  - mtime ticks every cycle while EN=1.
  - Offset 0x14 reads 0 and ignores writes.
  - No prescale logic is synthesized.

## Structure
- `timer_pkg` holds:
  - register offset localparams (`OFF_MTIME_LO` … `OFF_PRESC`);
  - the CTRL bit indices;
  - the FSM enum `timer_state_e` {IDLE, ARMED, FIRED, SERVICED};
  - the reset value of mtimecmp.
- One sub-module, `mtime_counter`, contains the 64-bit counter, the optional prescaler, write override and wrap. It outputs `mtime` and accepts the tick enable and CPU write strobes. Decode, compare and FSM stay in `timer_intr_ctrl`.

## Test plan
- Reset, write MTIMECMP_LO=5, MTIMECMP_HI=0, then CTRL=1:
  - `timer_intr` rises exactly 1 cycle after mtime reads 5.
  - CTRL reads 0x3.
- In FIRED, pulse `intr_ack`:
  - `timer_intr` falls the same edge.
  - It stays low while mtime keeps counting past mtimecmp.
  - After writing MTIMECMP_LO=mtime+3, it rises again 3 ticks later.
- Write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0xFFFF_FFFF with EN=1:
  - mtime reads 0 for both words the next cycle.
  - No interrupt fires with mtimecmp=10 until mtime reaches 10.
- Same-cycle MTIME_LO write of 0x100 and tick: MTIME_LO reads 0x100, not 0x101.
- In FIRED, write CTRL=0 together with `intr_ack`: state IDLE, `timer_intr`=0, mtime frozen.
- Read offset 0x18, or address BASE_ADDR+0x20: `rdata`=0. With `TIMER_PRESCALER_EN` and PRESC=3, mtime advances once every 4 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the machine-timer peripheral: register byte offsets, CTRL bits,
// FSM encoding and mtimecmp reset value. PRESC offset is only decoded with TIMER_PRESCALER_EN.
package timer_pkg;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_PRESC       = 5'h14;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_PEND_BIT = 1;

    localparam logic [63:0] MTIMECMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        FIRED    = 2'd2,
        SERVICED = 2'd3
    } timer_state_e;

endpackage

// File: rtl/mtime_counter.sv
// 64-bit mtime with wrap, CPU word-write override (a write drops that cycle's tick) and,
// under TIMER_PRESCALER_EN, an 8-bit prescaler; updates land 1 cycle after the edge, no backpressure.
module mtime_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
`ifdef TIMER_PRESCALER_EN
    input  logic        wr_presc,
    output logic [7:0]  presc,
`endif
    output logic [63:0] mtime
);

    logic [63:0] mtime_d, mtime_q;
    logic        tick;

`ifdef TIMER_PRESCALER_EN
    logic [7:0] presc_d, presc_q;
    logic [7:0] pcnt_d, pcnt_q;

    // The counter runs 0..PRESC and ticks on the wrap, so a tick occurs every PRESC+1 enabled cycles.
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        tick    = 1'b0;
        if (wr_presc) begin
            presc_d = wdata[7:0];
            pcnt_d  = 8'd0;
        end else if (tick_en) begin
            if (pcnt_q == presc_q) begin
                tick   = 1'b1;
                pcnt_d = 8'd0;
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign presc = presc_q;
`else
    assign tick = tick_en;
`endif

    always_comb begin
        mtime_d = mtime_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) mtime_d[31:0]  = wdata;
            if (wr_hi) mtime_d[63:32] = wdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime_q <= 64'd0;
        end else begin
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/timer_intr_ctrl.sv
// Memory-mapped machine timer: register decode, mtime >= mtimecmp compare FSM, level timer_intr held until ack.
// Reads combinational, writes and interrupt registered (1 cycle); no backpressure. TIMER_PRESCALER_EN adds PRESC.
module timer_intr_ctrl
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [31:0] rdata,
    input  logic        intr_ack,
    output logic        timer_intr
);

    logic         hit;
    logic [4:0]   off;
    logic         unused_addr_bits;
    logic         wr_mtime_lo, wr_mtime_hi;
    logic         wr_cmp_lo, wr_cmp_hi, wr_cmp;
    logic         wr_ctrl;
    logic [63:0]  mtime;
    logic [63:0]  mtimecmp_d, mtimecmp_q;
    logic         en_d, en_q;
    timer_state_e state_d, state_q;
    logic         intr_d, intr_q;

    assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
    assign off              = {addr[4:2], 2'b00};
    assign unused_addr_bits = ^addr[1:0];

    assign wr_mtime_lo = wr_en && hit && (off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr_en && hit && (off == OFF_MTIME_HI);
    assign wr_cmp_lo   = wr_en && hit && (off == OFF_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && hit && (off == OFF_MTIMECMP_HI);
    assign wr_cmp      = wr_cmp_lo || wr_cmp_hi;
    assign wr_ctrl     = wr_en && hit && (off == OFF_CTRL);

`ifdef TIMER_PRESCALER_EN
    logic       wr_presc;
    logic [7:0] presc;

    assign wr_presc = wr_en && hit && (off == OFF_PRESC);
`endif

    mtime_counter u_mtime_counter (
        .clk      (clk),
        .reset    (reset),
        .tick_en  (en_q),
        .wr_lo    (wr_mtime_lo),
        .wr_hi    (wr_mtime_hi),
        .wdata    (wdata),
`ifdef TIMER_PRESCALER_EN
        .wr_presc (wr_presc),
        .presc    (presc),
`endif
        .mtime    (mtime)
    );

    always_comb begin
        en_d       = en_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_ctrl)   en_d              = wdata[CTRL_EN_BIT];
        if (wr_cmp_lo) mtimecmp_d[31:0]  = wdata;
        if (wr_cmp_hi) mtimecmp_d[63:32] = wdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (wr_ctrl && wdata[CTRL_EN_BIT]) state_d = ARMED;
            ARMED:    if (mtime >= mtimecmp_q)           state_d = FIRED;
            // An ack racing a new compare value skips SERVICED so the new value is checked next cycle.
            FIRED:    if (intr_ack)                      state_d = wr_cmp ? ARMED : SERVICED;
            SERVICED: if (wr_cmp)                        state_d = ARMED;
            default:                                     state_d = IDLE;
        endcase
        if (wr_ctrl && !wdata[CTRL_EN_BIT]) state_d = IDLE;
    end

    assign intr_d = (state_d == FIRED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtimecmp_q <= MTIMECMP_RST_VAL;
            en_q       <= 1'b0;
            state_q    <= IDLE;
            intr_q     <= 1'b0;
        end else begin
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            state_q    <= state_d;
            intr_q     <= intr_d;
        end
    end

    assign timer_intr = intr_q;

    always_comb begin
        rdata = 32'd0;
        if (rd_en && hit) begin
            case (off)
                OFF_MTIME_LO:    rdata = mtime[31:0];
                OFF_MTIME_HI:    rdata = mtime[63:32];
                OFF_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
                OFF_CTRL: begin
                    rdata[CTRL_EN_BIT]   = en_q;
                    rdata[CTRL_PEND_BIT] = (state_q == FIRED);
                end
`ifdef TIMER_PRESCALER_EN
                OFF_PRESC:       rdata = {24'd0, presc};
`endif
                default:         rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Bench for timer_intr_ctrl: directed scenarios with literal expectations, then randomized bus traffic
// checked every cycle against a flag-and-arithmetic model of the timer (honours TIMER_PRESCALER_EN).
module tb_timer_intr_ctrl;

    localparam logic [31:0] BASE = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    logic        intr_ack;
    logic        timer_intr;

    always #5 clk = ~clk;

    timer_intr_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .rdata      (rdata),
        .intr_ack   (intr_ack),
        .timer_intr (timer_intr)
    );

    // Model: the interrupt is "pending" until acked, then "acked" until a new compare value arrives.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic        m_intr;
    logic        m_acked;
`ifdef TIMER_PRESCALER_EN
    logic [7:0]  m_presc;
    int          m_phase;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic       mh_wr, mh_tick, mh_cmp_w, mh_ctrl_w, mh_due;
    logic [2:0] mh_o;

    always @(posedge clk) begin
        if (!reset) begin
            m_mtime = 64'd0;
            m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_en    = 1'b0;
            m_intr  = 1'b0;
            m_acked = 1'b0;
`ifdef TIMER_PRESCALER_EN
            m_presc = 8'd0;
            m_phase = 0;
`endif
        end else begin
            mh_wr     = wr_en && (addr[31:5] == BASE[31:5]);
            mh_o      = addr[4:2];
            mh_due    = (m_mtime >= m_cmp);
            mh_cmp_w  = mh_wr && (mh_o == 3'd2 || mh_o == 3'd3);
            mh_ctrl_w = mh_wr && (mh_o == 3'd4);
`ifdef TIMER_PRESCALER_EN
            mh_tick = 1'b0;
            if (mh_wr && mh_o == 3'd5) begin
                m_presc = wdata[7:0];
                m_phase = 0;
            end else if (m_en) begin
                m_phase = (m_phase + 1) % (int'(m_presc) + 1);
                mh_tick = (m_phase == 0);
            end
`else
            mh_tick = m_en;
`endif
            if (mh_wr && mh_o == 3'd0)      m_mtime[31:0]  = wdata;
            else if (mh_wr && mh_o == 3'd1) m_mtime[63:32] = wdata;
            else if (mh_tick)               m_mtime        = m_mtime + 64'd1;

            if (mh_ctrl_w && !wdata[0]) begin
                m_intr  = 1'b0;
                m_acked = 1'b0;
            end else if (m_intr) begin
                if (intr_ack) begin
                    m_intr  = 1'b0;
                    m_acked = !mh_cmp_w;
                end
            end else if (m_acked) begin
                if (mh_cmp_w) m_acked = 1'b0;
            end else if (m_en && mh_due) begin
                m_intr = 1'b1;
            end

            if (mh_cmp_w && mh_o == 3'd2) m_cmp[31:0]  = wdata;
            if (mh_cmp_w && mh_o == 3'd3) m_cmp[63:32] = wdata;
            if (mh_ctrl_w)                m_en         = wdata[0];
        end
    end

    function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
        if (!r || a[31:5] != BASE[31:5]) return 32'd0;
        case (a[4:2])
            3'd0: return m_mtime[31:0];
            3'd1: return m_mtime[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_intr, m_en};
`ifdef TIMER_PRESCALER_EN
            3'd5: return {24'd0, m_presc};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs();
        logic [31:0] er;
        er = m_read(rd_en, addr);
        n_checks++;
        if (timer_intr !== m_intr) begin
            n_fail++;
            $display("FAIL model_intr t=%0t got=%b exp=%b", $time, timer_intr, m_intr);
        end
        n_checks++;
        if (rdata !== er) begin
            n_fail++;
            $display("FAIL model_rdata t=%0t addr=%h got=%h exp=%h", $time, addr, rdata, er);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are compared on the falling edge.
    task automatic cycle(input logic rst, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d, input logic ack);
        @(posedge clk);
        #1;
        reset    = rst;
        wr_en    = w;
        rd_en    = r;
        addr     = a;
        wdata    = d;
        intr_ack = ack;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cycle(1'b1, 1'b1, 1'b0, BASE + off, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] off);
        cycle(1'b1, 1'b0, 1'b1, BASE + off, 32'd0, 1'b0);
    endtask

    logic        found;
    logic [31:0] m0;
    logic [2:0]  ro;
    logic [31:0] ra, rd_v;

    initial begin
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 32'd0; wdata = 32'd0; intr_ack = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        rd(32'h10); chk("rst_ctrl", rdata, 32'd0);
        rd(32'h0C); chk("rst_cmp_hi", rdata, 32'hFFFF_FFFF);
        rd(32'h00); chk("rst_mtime_lo", rdata, 32'd0);
        chk("rst_intr", {31'd0, timer_intr}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, BASE, 32'd0, 1'b0);
        chk("rdata_idle_zero", rdata, 32'd0);

        // Compare fires one cycle after mtime reaches 5.
        wr(32'h08, 32'd5); wr(32'h0C, 32'd0); wr(32'h10, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            rd(32'h00);
            if (rdata == 32'd5) found = 1'b1;
        end
        chk("mtime_reached_5", rdata, 32'd5);
        chk("intr_low_at_match", {31'd0, timer_intr}, 32'd0);
        rd(32'h10);
        chk("intr_rise", {31'd0, timer_intr}, 32'd1);
        chk("ctrl_pend", rdata, 32'd3);

        // Ack drops the interrupt; it stays low until mtimecmp is rewritten.
        cycle(1'b1, 1'b0, 1'b0, BASE, 32'd0, 1'b1);
        rd(32'h00); chk("intr_fall_on_ack", {31'd0, timer_intr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(32'h00); chk("intr_stays_low", {31'd0, timer_intr}, 32'd0);
        end
        m0 = rdata;
        cycle(1'b1, 1'b1, 1'b0, BASE + 32'h08, m0 + 32'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd(32'h10); chk("intr_wait_rearm", {31'd0, timer_intr}, 32'd0);
        end
        rd(32'h10); chk("intr_rearm_rise", {31'd0, timer_intr}, 32'd1);

        // Wrap from all-ones; ack and compare write together re-arm against mtimecmp=10.
        wr(32'h00, 32'hFFFF_FFFF); wr(32'h04, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 1'b0, BASE + 32'h08, 32'd10, 1'b1);
        rd(32'h04); chk("wrap_hi_zero", rdata, 32'd0);
        chk("wrap_no_intr", {31'd0, timer_intr}, 32'd0);
        rd(32'h00); chk("wrap_lo", rdata, 32'd1);
        for (int i = 2; i <= 11; i++) begin
            rd(32'h00);
            chk("wrap_count", rdata, i);
            chk("wrap_intr", {31'd0, timer_intr}, (i >= 11) ? 32'd1 : 32'd0);
        end

        wr(32'h00, 32'h100);
        rd(32'h00); chk("write_beats_tick", rdata, 32'h100);

        // Disable while FIRED together with ack: idle, no interrupt, mtime frozen.
        cycle(1'b1, 1'b1, 1'b0, BASE + 32'h10, 32'd0, 1'b1);
        rd(32'h10);
        chk("disable_ctrl", rdata, 32'd0);
        chk("disable_intr", {31'd0, timer_intr}, 32'd0);
        rd(32'h00); chk("frozen_1", rdata, 32'h102);
        rd(32'h00); chk("frozen_2", rdata, 32'h102);

        rd(32'h18); chk("reserved_rd", rdata, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, BASE + 32'h20, 32'h55, 1'b0);
        chk("outside_rd", rdata, 32'd0);
        rd(32'h00); chk("outside_wr_ignored", rdata, 32'h102);

`ifdef TIMER_PRESCALER_EN
        wr(32'h14, 32'd3); wr(32'h10, 32'd1);
        rd(32'h14); chk("presc_rd", rdata, 32'd3);
        for (int i = 1; i <= 8; i++) begin
            rd(32'h00); chk("presc_tick", rdata, 32'h102 + i / 4);
        end
`else
        wr(32'h14, 32'd3);
        rd(32'h14); chk("presc_absent", rdata, 32'd0);
        wr(32'h10, 32'd1);
        rd(32'h00); chk("tick_1", rdata, 32'h102);
        rd(32'h00); chk("tick_2", rdata, 32'h103);
`endif
        rd(32'h10); chk("refire", {31'd0, timer_intr}, 32'd1);

        // Synchronous reset mid-operation.
        cycle(1'b0, 1'b0, 1'b0, BASE, 32'd0, 1'b0);
        rd(32'h10);
        chk("reset_ctrl", rdata, 32'd0);
        chk("reset_intr", {31'd0, timer_intr}, 32'd0);
        rd(32'h00); chk("reset_mtime", rdata, 32'd0);
        rd(32'h08); chk("reset_cmp_lo", rdata, 32'hFFFF_FFFF);

        for (int n = 0; n < 3000; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = BASE + {27'd0, ro, 2'b00} + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0)
                ra = ($urandom_range(0, 1) == 0) ? (BASE + 32'h20 + {27'd0, ro, 2'b00}) : $urandom;
            case (ro)
                3'd0, 3'd1, 3'd2, 3'd3:
                    rd_v = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 40);
                3'd4: begin
                    rd_v    = $urandom;
                    rd_v[0] = ($urandom_range(0, 4) != 0);
                end
                3'd5: begin
                    rd_v      = $urandom;
                    rd_v[7:0] = 8'($urandom_range(0, 3));
                end
                default: rd_v = $urandom;
            endcase
            cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 1), ra, rd_v, ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
